// File: rtl/ppu_pkg.sv
// Shared constants and types for the ppu blocks: display timing, table-select
// encoding of address[9:8], the commit-marker address and the write-buffer states.
package ppu_pkg;

    localparam int unsigned VACTIVE = 480;
    localparam int unsigned HTOTAL  = 1600;

    localparam logic [15:0] COMMIT_ADDR = 16'h0300;

    typedef enum logic [1:0] {
        TBL_ATTR   = 2'b00,
        TBL_SPRITE = 2'b01,
        TBL_COLOR  = 2'b10,
        TBL_CTRL   = 2'b11
    } tbl_sel_t;

    typedef enum logic [1:0] {
        HOLD,
        DRAIN,
        DONE
    } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous single-clock FIFO with a registered read port: a pop loads the
// head into rd_data, which then holds until the next pop.
module wb_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_rd_data <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign rd_data = r_rd_data;
    assign level   = r_level;
    assign full    = (r_level == LVL_W'(DEPTH));
    assign empty   = (r_level == '0);

endmodule

// File: rtl/ppu_write_buffer.sv
// Queues CPU table writes during active display and replays them to the ppu
// during vertical blanking. Define PPU_WB_COMMIT_EN for commit-marker gating.
module ppu_write_buffer
    import ppu_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    chipselect,
    input  logic                    write,
    input  logic [ADDR_W-1:0]       address,
    input  logic [DATA_W-1:0]       writedata,
    input  logic [10:0]             hcount,
    input  logic [9:0]              vcount,
    output logic                    out_write,
    output logic [ADDR_W-1:0]       out_address,
    output logic [DATA_W-1:0]       out_writedata,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic [7:0]              dropped
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    wb_state_t                  r_state;
    logic                       r_out_write;
    logic [7:0]                 r_dropped;
    logic                       w_push_req;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_eligible;
    logic                       w_empty;
    logic                       w_vblank_start;
    logic                       w_frame_start;
    logic [ADDR_W+DATA_W-1:0]   w_rd_data;

    assign w_vblank_start = (vcount == 10'(VACTIVE)) && (hcount == '0);
    assign w_frame_start  = (vcount == '0) && (hcount == '0);

`ifdef PPU_WB_COMMIT_EN
    logic             w_commit;
    logic [LVL_W-1:0] r_committed;

    assign w_commit   = chipselect && write && (address == ADDR_W'(COMMIT_ADDR));
    assign w_push_req = chipselect && write && !w_commit;
    assign w_eligible = !w_empty && (r_committed != '0);

    // A commit snapshots the post-pop occupancy; pops then consume the snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_committed <= '0;
        end else if (w_commit) begin
            r_committed <= w_pop ? level - LVL_W'(1) : level;
        end else if (w_pop) begin
            r_committed <= r_committed - LVL_W'(1);
        end
    end
`else
    assign w_push_req = chipselect && write;
    assign w_eligible = !w_empty;
`endif

    assign w_push = w_push_req && !full;
    assign w_pop  = (r_state == DRAIN) && w_eligible && !w_frame_start;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data ({address, writedata}),
        .rd_data (w_rd_data),
        .level   (level),
        .full    (full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HOLD;
            r_out_write <= 1'b0;
            r_dropped   <= '0;
        end else begin
            r_out_write <= w_pop;
            if (w_push_req && full && (r_dropped != 8'hFF)) begin
                r_dropped <= r_dropped + 8'd1;
            end
            case (r_state)
                HOLD: begin
                    if (w_vblank_start) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_frame_start)    r_state <= HOLD;
                    else if (!w_eligible) r_state <= DONE;
                end
                DONE: begin
                    if (w_frame_start) r_state <= HOLD;
                end
                default: r_state <= HOLD;
            endcase
        end
    end

    assign out_write     = r_out_write;
    assign out_address   = w_rd_data[ADDR_W+DATA_W-1:DATA_W];
    assign out_writedata = w_rd_data[DATA_W-1:0];
    assign dropped       = r_dropped;

endmodule

// File: tb/tb_ppu_write_buffer.sv
// Directed bench for ppu_write_buffer: a vector table for the basic drain and
// push/pop overlap, plus sequences for overflow, reset mid-drain and commit gating.
module tb_ppu_write_buffer;

    logic        clk;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic [15:0] address;
    logic [31:0] writedata;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        out_write;
    logic [15:0] out_address;
    logic [31:0] out_writedata;
    logic [5:0]  level;
    logic        full;
    logic [7:0]  dropped;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    ppu_write_buffer #(
        .DEPTH  (32),
        .ADDR_W (16),
        .DATA_W (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .chipselect    (chipselect),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .hcount        (hcount),
        .vcount        (vcount),
        .out_write     (out_write),
        .out_address   (out_address),
        .out_writedata (out_writedata),
        .level         (level),
        .full          (full),
        .dropped       (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        cs;
        logic [15:0] addr;
        logic [31:0] data;
        logic [10:0] hc;
        logic [9:0]  vc;
        logic        ow;
        logic [15:0] oa;
        logic [31:0] od;
        logic [5:0]  lvl;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cs, input logic [15:0] a, input logic [31:0] d,
                         input logic [10:0] hc, input logic [9:0] vc);
        chipselect = cs;
        write      = cs;
        address    = a;
        writedata  = d;
        hcount     = hc;
        vcount     = vc;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, '0, 11'd50, 10'd100);
        tick();
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic rst, input logic cs, input logic [15:0] a,
                                input logic [31:0] d, input logic [10:0] hc,
                                input logic [9:0] vc, input logic ow,
                                input logic [15:0] oa, input logic [31:0] od,
                                input logic [5:0] lvl);
        vec_t v;
        v.rst = rst; v.cs = cs; v.addr = a; v.data = d; v.hc = hc; v.vc = vc;
        v.ow = ow; v.oa = oa; v.od = od; v.lvl = lvl;
        return v;
    endfunction

    vec_t tbl[24];

    initial begin
        int unsigned pops;
        logic [15:0] exp_a;

        reset = 1'b1;
        drive(1'b0, '0, '0, '0, '0);

`ifndef PPU_WB_COMMIT_EN
        // Three writes held through active display, then drained at vblank.
        tbl[0]  = mk(1, 0, 16'h0000, 32'h0,         11'd0, 10'd0,   0, 16'h0000, 32'h0,         6'd0);
        tbl[1]  = mk(0, 1, 16'h0001, 32'hAAAA0001, 11'd5, 10'd100, 0, 16'h0000, 32'h0,         6'd1);
        tbl[2]  = mk(0, 1, 16'h0002, 32'hAAAA0002, 11'd6, 10'd100, 0, 16'h0000, 32'h0,         6'd2);
        tbl[3]  = mk(0, 1, 16'h0003, 32'hAAAA0003, 11'd7, 10'd100, 0, 16'h0000, 32'h0,         6'd3);
        tbl[4]  = mk(0, 0, 16'h0000, 32'h0,         11'd8, 10'd100, 0, 16'h0000, 32'h0,         6'd3);
        tbl[5]  = mk(0, 0, 16'h0000, 32'h0,         11'd0, 10'd480, 0, 16'h0000, 32'h0,         6'd3);
        tbl[6]  = mk(0, 0, 16'h0000, 32'h0,         11'd1, 10'd480, 1, 16'h0001, 32'hAAAA0001, 6'd2);
        tbl[7]  = mk(0, 0, 16'h0000, 32'h0,         11'd2, 10'd480, 1, 16'h0002, 32'hAAAA0002, 6'd1);
        tbl[8]  = mk(0, 0, 16'h0000, 32'h0,         11'd3, 10'd480, 1, 16'h0003, 32'hAAAA0003, 6'd0);
        tbl[9]  = mk(0, 0, 16'h0000, 32'h0,         11'd4, 10'd480, 0, 16'h0003, 32'hAAAA0003, 6'd0);
        tbl[10] = mk(0, 0, 16'h0000, 32'h0,         11'd0, 10'd0,   0, 16'h0003, 32'hAAAA0003, 6'd0);
        // Five queued, then a push lands on the first drain pop.
        for (int i = 0; i < 5; i++)
            tbl[11+i] = mk(0, 1, 16'h0010 + 16'(i), 32'hB0000000 + 32'(i), 11'd10 + 11'(i), 10'd10,
                           0, 16'h0003, 32'hAAAA0003, 6'(i + 1));
        tbl[16] = mk(0, 0, 16'h0000, 32'h0,         11'd0, 10'd480, 0, 16'h0003, 32'hAAAA0003, 6'd5);
        tbl[17] = mk(0, 1, 16'h0020, 32'hC0000020, 11'd1, 10'd480, 1, 16'h0010, 32'hB0000000, 6'd5);
        for (int i = 1; i < 5; i++)
            tbl[17+i] = mk(0, 0, 16'h0000, 32'h0, 11'd1 + 11'(i), 10'd480,
                           1, 16'h0010 + 16'(i), 32'hB0000000 + 32'(i), 6'(5 - i));
        tbl[22] = mk(0, 0, 16'h0000, 32'h0,         11'd6, 10'd480, 1, 16'h0020, 32'hC0000020, 6'd0);
        tbl[23] = mk(0, 0, 16'h0000, 32'h0,         11'd7, 10'd480, 0, 16'h0020, 32'hC0000020, 6'd0);

        for (int i = 0; i < 24; i++) begin
            reset = tbl[i].rst;
            drive(tbl[i].cs, tbl[i].addr, tbl[i].data, tbl[i].hc, tbl[i].vc);
            tick();
            chk($sformatf("vec%0d_write", i), 32'(out_write), 32'(tbl[i].ow));
            chk($sformatf("vec%0d_addr", i),  32'(out_address), 32'(tbl[i].oa));
            chk($sformatf("vec%0d_data", i),  out_writedata, tbl[i].od);
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("vec%0d_full", i),  32'(full), 32'(0));
        end

        // Overflow: 34 pushes into 32 entries, then drain exactly 1..32.
        do_reset();
        chk("reset_dropped", 32'(dropped), 32'd0);
        for (int i = 1; i <= 34; i++) begin
            drive(1'b1, 16'(i), 32'hD0000000 + 32'(i), 11'(i), 10'd100);
            tick();
            if (i == 31) chk("full_at_31", 32'(full), 32'd0);
            if (i == 32) begin
                chk("full_at_32", 32'(full), 32'd1);
                chk("level_at_32", 32'(level), 32'd32);
            end
        end
        chk("dropped_2", 32'(dropped), 32'd2);
        chk("level_still_32", 32'(level), 32'd32);
        drive(1'b0, '0, '0, 11'd0, 10'd480);
        tick();
        chk("no_early_write", 32'(out_write), 32'd0);
        for (int i = 1; i <= 32; i++) begin
            drive(1'b0, '0, '0, 11'(i), 10'd480);
            tick();
            chk($sformatf("drain%0d_write", i), 32'(out_write), 32'd1);
            chk($sformatf("drain%0d_addr", i), 32'(out_address), 32'(i));
            chk($sformatf("drain%0d_data", i), out_writedata, 32'hD0000000 + 32'(i));
        end
        drive(1'b0, '0, '0, 11'd40, 10'd480);
        tick();
        chk("drain_end_write", 32'(out_write), 32'd0);
        chk("drain_end_level", 32'(level), 32'd0);
        chk("drain_end_full", 32'(full), 32'd0);

        // Drop counter saturation.
        do_reset();
        for (int i = 0; i < 332; i++) begin
            drive(1'b1, 16'h0100, 32'(i), 11'd100, 10'd200);
            tick();
            if (i == 286) chk("dropped_255", 32'(dropped), 32'd255);
        end
        chk("dropped_sat", 32'(dropped), 32'd255);

        // Reset after 2 of 6 drain pops.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'h0040 + 16'(i), 32'hE0000000 + 32'(i), 11'd20 + 11'(i), 10'd50);
            tick();
        end
        drive(1'b0, '0, '0, 11'd0, 10'd480);
        tick();
        drive(1'b0, '0, '0, 11'd1, 10'd480);
        tick();
        chk("rst_pop1", 32'(out_address), 32'h40);
        drive(1'b0, '0, '0, 11'd2, 10'd480);
        tick();
        chk("rst_pop2", 32'(out_address), 32'h41);
        chk("rst_pop2_write", 32'(out_write), 32'd1);
        reset = 1'b1;
        drive(1'b0, '0, '0, 11'd3, 10'd480);
        tick();
        reset = 1'b0;
        chk("rst_write_low", 32'(out_write), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        pops = 0;
        drive(1'b0, '0, '0, 11'd0, 10'd0);
        tick();
        drive(1'b0, '0, '0, 11'd0, 10'd480);
        tick();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, '0, '0, 11'(i), 10'd480);
            tick();
            if (out_write) pops++;
        end
        chk("rst_no_replay", pops, 0);

        // The commit address is an ordinary write in this build.
        drive(1'b1, 16'h0300, 32'h12345678, 11'd5, 10'd10);
        tick();
        chk("addr300_stored", 32'(level), 32'd1);
`else
        // Commit gating: 4 committed, 2 held until a later commit.
        do_reset();
        chk("reset_level", 32'(level), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h0050 + 16'(i), 32'hF0000000 + 32'(i), 11'd10 + 11'(i), 10'd100);
            tick();
        end
        drive(1'b1, 16'h0300, 32'h0, 11'd20, 10'd100);
        tick();
        chk("commit_not_stored", 32'(level), 32'd4);
        for (int i = 4; i < 6; i++) begin
            drive(1'b1, 16'h0050 + 16'(i), 32'hF0000000 + 32'(i), 11'd30 + 11'(i), 10'd100);
            tick();
        end
        chk("level_6", 32'(level), 32'd6);
        for (int f = 0; f < 3; f++) begin
            if (f == 2) begin
                drive(1'b1, 16'h0300, 32'h0, 11'd5, 10'd10);
                tick();
            end
            drive(1'b0, '0, '0, 11'd0, 10'd480);
            tick();
            pops = 0;
            exp_a = (f == 0) ? 16'h0050 : 16'h0054;
            for (int i = 1; i <= 10; i++) begin
                drive(1'b0, '0, '0, 11'(i), 10'd480);
                tick();
                if (out_write) begin
                    chk($sformatf("f%0d_addr", f), 32'(out_address), 32'(exp_a));
                    exp_a++;
                    pops++;
                end
            end
            chk($sformatf("f%0d_pops", f), pops, (f == 0) ? 4 : (f == 1) ? 0 : 2);
            chk($sformatf("f%0d_level", f), 32'(level), (f == 2) ? 32'd0 : 32'd2);
            drive(1'b0, '0, '0, 11'd0, 10'd0);
            tick();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
